// File: rtl/wb_pkg.sv
// Shared defaults and queue entry layout for the writeback arbiter.
package wb_pkg;

    localparam int unsigned WB_DW    = 16;
    localparam int unsigned WB_AW    = 3;
    localparam int unsigned WB_DEPTH = 4;

    // One pending register write; rd sits above data in the packed layout.
    typedef struct packed {
        logic [WB_AW-1:0] rd;
        logic [WB_DW-1:0] data;
    } wb_entry_t;

    // Build an entry from its fields.
    function automatic wb_entry_t wb_entry(input logic [WB_AW-1:0] rd,
                                           input logic [WB_DW-1:0] data);
        wb_entry_t e;
        e.rd   = rd;
        e.data = data;
        return e;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer with two ordered write ports and one read port.
// din0 is always placed ahead of din1; din1 alone takes the next free slot.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned W     = WB_AW + WB_DW,
    parameter int unsigned DEPTH = WB_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push0,
    input  logic                     push1,
    input  logic [W-1:0]             din0,
    input  logic [W-1:0]             din1,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] rptr_q;
    logic [CW-1:0] count_q;
    logic [PW-1:0] widx1;
    logic [1:0]    nwr;

    // Lane 1 lands behind lane 0 only when lane 0 also pushes.
    always_comb begin
        widx1 = push0 ? wptr_q + PW'(1) : wptr_q;
        nwr   = {1'b0, push0} + {1'b0, push1};
    end

    // Storage: no reset needed, validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push0) mem[wptr_q] <= din0;
        if (push1) mem[widx1]  <= din1;
    end

    // Pointers wrap naturally modulo DEPTH (power of two).
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_q + PW'(nwr);
            rptr_q  <= rptr_q + PW'(pop);
            count_q <= count_q + CW'(nwr) - CW'(pop);
        end
    end

    assign head  = mem[rptr_q];
    assign count = count_q;

endmodule

// File: rtl/wb_arbiter.sv
// Two-lane writeback arbiter: queues lane results in program order and
// retires at most one register-file write per cycle.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned DW    = WB_DW,
    parameter int unsigned AW    = WB_AW,
    parameter int unsigned DEPTH = WB_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     l0_iswb,
    input  logic                     l0_isld,
    input  logic [AW-1:0]            l0_rd,
    input  logic [DW-1:0]            l0_aluresult,
    input  logic [DW-1:0]            l0_ldresult,
    input  logic                     l1_iswb,
    input  logic                     l1_isld,
    input  logic [AW-1:0]            l1_rd,
    input  logic [DW-1:0]            l1_aluresult,
    input  logic [DW-1:0]            l1_ldresult,
    output logic                     in_ready,
    output logic                     rf_we,
    output logic [AW-1:0]            rf_waddr,
    output logic [DW-1:0]            rf_wdata,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned EW = AW + DW;

    logic          acc0;
    logic          acc1;
    logic          pop;
    logic [EW-1:0] ent0;
    logic [EW-1:0] ent1;
    logic [EW-1:0] head;
    logic [CW-1:0] count;

    logic          rf_we_q;
    logic [AW-1:0] rf_waddr_q;
    logic [DW-1:0] rf_wdata_q;

    // Ready depends only on registered occupancy: room for two is required
    // because both lanes may push in the same cycle.
    always_comb begin
        in_ready = (count <= CW'(DEPTH - 2));
        acc0     = l0_iswb & in_ready;
        acc1     = l1_iswb & in_ready;
        ent0     = {l0_rd, (l0_isld ? l0_ldresult : l0_aluresult)};
        ent1     = {l1_rd, (l1_isld ? l1_ldresult : l1_aluresult)};
        pop      = (count != '0);
    end

    wb_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push0 (acc0),
        .push1 (acc1),
        .din0  (ent0),
        .din1  (ent1),
        .pop   (pop),
        .head  (head),
        .count (count)
    );

    // Register-file write port; address/data hold when nothing retires.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_we_q <= pop;
            if (pop) begin
                rf_waddr_q <= head[EW-1:DW];
                rf_wdata_q <= head[DW-1:0];
            end
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign occupancy = count;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter (DW=16, AW=3, DEPTH=4).
module tb_wb_arbiter;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        l0_iswb, l0_isld, l1_iswb, l1_isld;
    logic [2:0]  l0_rd, l1_rd;
    logic [15:0] l0_aluresult, l0_ldresult, l1_aluresult, l1_ldresult;
    logic        in_ready, rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [2:0]  occupancy;

    int checks = 0;
    int errors = 0;

    wb_entry_t   wr_q[$];
    logic [15:0] regs [8];

    wb_arbiter #(.DW(16), .AW(3), .DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .l0_iswb      (l0_iswb),
        .l0_isld      (l0_isld),
        .l0_rd        (l0_rd),
        .l0_aluresult (l0_aluresult),
        .l0_ldresult  (l0_ldresult),
        .l1_iswb      (l1_iswb),
        .l1_isld      (l1_isld),
        .l1_rd        (l1_rd),
        .l1_aluresult (l1_aluresult),
        .l1_ldresult  (l1_ldresult),
        .in_ready     (in_ready),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .occupancy    (occupancy)
    );

    always #5 clk = ~clk;

    // Record every retired write and keep a register-file image.
    always @(negedge clk) begin
        if (rf_we) begin
            wr_q.push_back(wb_entry(rf_waddr, rf_wdata));
            regs[rf_waddr] = rf_wdata;
        end
    end

    task automatic clear_lanes();
        l0_iswb = 0; l0_isld = 0; l0_rd = 0; l0_aluresult = 0; l0_ldresult = 0;
        l1_iswb = 0; l1_isld = 0; l1_rd = 0; l1_aluresult = 0; l1_ldresult = 0;
    endtask

    task automatic drive(input logic wb0, input logic ld0, input logic [2:0] rd0,
                         input logic [15:0] alu0, input logic [15:0] ldr0,
                         input logic wb1, input logic ld1, input logic [2:0] rd1,
                         input logic [15:0] alu1, input logic [15:0] ldr1);
        l0_iswb = wb0; l0_isld = ld0; l0_rd = rd0; l0_aluresult = alu0; l0_ldresult = ldr0;
        l1_iswb = wb1; l1_isld = ld1; l1_rd = rd1; l1_aluresult = alu1; l1_ldresult = ldr1;
    endtask

    task automatic test_reset();
        rst = 1;
        clear_lanes();
        repeat (2) @(negedge clk);
        rst = 0;
        checks++;
        if (rf_we !== 1'b0 || rf_waddr !== 3'd0 || rf_wdata !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: got we=%b addr=%0d data=%h want 0/0/0000",
                     rf_we, rf_waddr, rf_wdata);
        end
        checks++;
        if (occupancy !== 3'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_occ: got occ=%0d rdy=%b want 0/1", occupancy, in_ready);
        end
    endtask

    task automatic test_single();
        drive(1, 0, 3'd1, 16'hABCD, 16'h5555, 0, 0, 3'd0, 16'h0, 16'h0);
        @(negedge clk);
        clear_lanes();
        checks++;
        if (occupancy !== 3'd1 || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL single_queued: got occ=%0d we=%b want 1/0", occupancy, rf_we);
        end
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 3'd1 || rf_wdata !== 16'hABCD) begin
            errors++;
            $display("FAIL single_write: got we=%b addr=%0d data=%h want 1/1/abcd",
                     rf_we, rf_waddr, rf_wdata);
        end
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b0 || occupancy !== 3'd0) begin
            errors++;
            $display("FAIL single_idle: got we=%b occ=%0d want 0/0", rf_we, occupancy);
        end
    endtask

    task automatic test_dual();
        drive(1, 1, 3'd2, 16'h9999, 16'h1234, 1, 0, 3'd3, 16'h5678, 16'h7777);
        @(negedge clk);
        clear_lanes();
        checks++;
        if (occupancy !== 3'd2) begin
            errors++;
            $display("FAIL dual_occ: got %0d want 2", occupancy);
        end
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 3'd2 || rf_wdata !== 16'h1234) begin
            errors++;
            $display("FAIL dual_first: got we=%b addr=%0d data=%h want 1/2/1234",
                     rf_we, rf_waddr, rf_wdata);
        end
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 3'd3 || rf_wdata !== 16'h5678) begin
            errors++;
            $display("FAIL dual_second: got we=%b addr=%0d data=%h want 1/3/5678",
                     rf_we, rf_waddr, rf_wdata);
        end
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b0 || occupancy !== 3'd0) begin
            errors++;
            $display("FAIL dual_idle: got we=%b occ=%0d want 0/0", rf_we, occupancy);
        end
    endtask

    task automatic test_waw();
        wr_q.delete();
        drive(1, 0, 3'd4, 16'h1111, 16'h0000, 1, 1, 3'd4, 16'h0000, 16'h2222);
        @(negedge clk);
        clear_lanes();
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (wr_q.size() !== 2) begin
            errors++;
            $display("FAIL waw_count: got %0d writes want 2", wr_q.size());
        end else begin
            checks++;
            if (wr_q[0] !== wb_entry(3'd4, 16'h1111) || wr_q[1] !== wb_entry(3'd4, 16'h2222)) begin
                errors++;
                $display("FAIL waw_order: got %h,%h want 41111,42222", wr_q[0], wr_q[1]);
            end
        end
        checks++;
        if (regs[4] !== 16'h2222) begin
            errors++;
            $display("FAIL waw_final: got reg4=%h want 2222", regs[4]);
        end
    endtask

    // Lane 1 alone, and a write to r0 which is not hardwired.
    task automatic test_lane1_and_r0();
        wr_q.delete();
        drive(0, 0, 3'd0, 16'h0, 16'h0, 1, 0, 3'd5, 16'h0BEE, 16'hDEAD);
        @(negedge clk);
        checks++;
        if (occupancy !== 3'd1) begin
            errors++;
            $display("FAIL lane1_occ: got %0d want 1", occupancy);
        end
        drive(1, 0, 3'd0, 16'h0F0F, 16'hDEAD, 0, 0, 3'd0, 16'h0, 16'h0);
        @(negedge clk);
        clear_lanes();
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (wr_q.size() !== 2) begin
            errors++;
            $display("FAIL lane1_count: got %0d writes want 2", wr_q.size());
        end else begin
            checks++;
            if (wr_q[0] !== wb_entry(3'd5, 16'h0BEE) || wr_q[1] !== wb_entry(3'd0, 16'h0F0F)) begin
                errors++;
                $display("FAIL lane1_r0: got %h,%h want 50bee,00f0f", wr_q[0], wr_q[1]);
            end
        end
    endtask

    task automatic test_no_wb();
        wr_q.delete();
        drive(0, 0, 3'd6, 16'hFEDC, 16'hFEDC, 0, 1, 3'd7, 16'hFEDC, 16'hFEDC);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (rf_we !== 1'b0 || occupancy !== 3'd0) begin
                errors++;
                $display("FAIL no_wb_cycle%0d: got we=%b occ=%0d want 0/0", i, rf_we, occupancy);
            end
        end
        clear_lanes();
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_d [6];
        int          stalls;
        int          max_occ;
        logic        acc;
        exp_d[0] = 16'hA001; exp_d[1] = 16'hA002; exp_d[2] = 16'hA003;
        exp_d[3] = 16'hA004; exp_d[4] = 16'hA005; exp_d[5] = 16'hA006;
        wr_q.delete();
        stalls  = 0;
        max_occ = 0;
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 3'(2 * k + 1), exp_d[2 * k], 16'h0,
                  1, 1, 3'(2 * k + 2), 16'h0, exp_d[2 * k + 1]);
            acc = 0;
            for (int t = 0; t < 20 && !acc; t++) begin
                acc = in_ready;
                if (!in_ready) stalls++;
                checks++;
                if (in_ready !== (occupancy <= 3'd2)) begin
                    errors++;
                    $display("FAIL bp_ready: got rdy=%b at occ=%0d", in_ready, occupancy);
                end
                @(negedge clk);
                if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
            end
            checks++;
            if (!acc) begin
                errors++;
                $display("FAIL bp_timeout: pair %0d not accepted within 20 cycles", k);
            end
        end
        clear_lanes();
        repeat (8) @(negedge clk);
        #1;
        checks++;
        if (stalls !== 1 || max_occ !== 3) begin
            errors++;
            $display("FAIL bp_stall: got stalls=%0d max_occ=%0d want 1/3", stalls, max_occ);
        end
        checks++;
        if (wr_q.size() !== 6 || occupancy !== 3'd0) begin
            errors++;
            $display("FAIL bp_drain: got %0d writes occ=%0d want 6/0", wr_q.size(), occupancy);
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (wr_q[i] !== wb_entry(3'(i + 1), exp_d[i])) begin
                    errors++;
                    $display("FAIL bp_order%0d: got %h want rd=%0d data=%h",
                             i, wr_q[i], i + 1, exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        drive(1, 0, 3'd6, 16'hC001, 16'h0, 1, 0, 3'd7, 16'hC002, 16'h0);
        @(negedge clk);
        drive(1, 0, 3'd1, 16'hC003, 16'h0, 1, 0, 3'd2, 16'hC004, 16'h0);
        @(negedge clk);
        checks++;
        if (occupancy !== 3'd3) begin
            errors++;
            $display("FAIL mid_fill: got occ=%0d want 3", occupancy);
        end
        // Reset must win over a live request in the same cycle.
        rst = 1;
        drive(1, 0, 3'd3, 16'hC005, 16'h0, 0, 0, 3'd0, 16'h0, 16'h0);
        @(negedge clk);
        rst = 0;
        clear_lanes();
        checks++;
        if (rf_we !== 1'b0 || occupancy !== 3'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: got we=%b occ=%0d rdy=%b want 0/0/1",
                     rf_we, occupancy, in_ready);
        end
        checks++;
        if (rf_waddr !== 3'd0 || rf_wdata !== 16'h0) begin
            errors++;
            $display("FAIL mid_regs: got addr=%0d data=%h want 0/0000", rf_waddr, rf_wdata);
        end
        wr_q.delete();
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (wr_q.size() !== 0) begin
            errors++;
            $display("FAIL mid_discard: got %0d writes after reset want 0", wr_q.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) regs[i] = 16'h0;
        rst = 1;
        clear_lanes();
        @(negedge clk);
        test_reset();
        test_single();
        test_dual();
        test_waw();
        test_lane1_and_r0();
        test_no_wb();
        test_back_to_back();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DW, 16, register data width.
REQ-002 Parameter AW, 3, register address width (8 architectural registers).
REQ-003 Parameter DEPTH, 4, writeback queue entries (power of two, >=2).
REQ-004 Clocking SHALL be one clock, clk; reset is synchronous and active-high, rst.
REQ-005 clk  in  1  sole clock, all state on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 l0_iswb  in  1  lane 0 (older in program order) requests writeback.
REQ-008 l0_isld  in  1  lane 0 result is a load: select l0_ldresult, else l0_aluresult.
REQ-009 l0_rd  in  AW  lane 0 destination register.
REQ-010 l0_aluresult, l0_ldresult  in  DW  lane 0 candidate results.
REQ-011 l1_iswb, l1_isld, l1_rd, l1_aluresult, l1_ldresult  in  1/1/AW/DW/DW  lane 1 (younger), same meaning.
REQ-012 in_ready  out  1  both lanes may present this cycle; low = issue stall.
REQ-013 rf_we  out  1  register-file write enable.
REQ-014 rf_waddr  out  AW  register-file write address.
REQ-015 rf_wdata  out  DW  register-file write data.
REQ-016 occupancy  out  clog2(DEPTH)+1  queued entries not yet written.

Function
REQ-017 Per-lane data SHALL be isld ? ldresult : aluresult, resolved at acceptance.
REQ-018 Accept: lane N accepted in cycle when laneN_iswb=1 and in_ready=1; requests with in_ready=0 are ignored (requester holds them).
REQ-019 in_ready SHALL be 1 iff occupancy <= DEPTH-2, from registered state only (no combinational path from inputs).
REQ-020 Same-cycle acceptance of both lanes SHALL enqueue lane 0 before lane 1; lane 1 alone enqueues as one entry; no empty slots.
REQ-021 Exactly one register write per cycle maximum: when queue non-empty, head is dequeued and rf_we/rf_waddr/rf_wdata registered from it; written on the next rising edge.
REQ-022 Latency: a request accepted into an empty queue at edge T SHALL appear as rf_we=1 in cycle T+1; lane 1 of a dual acceptance in T+2.
REQ-023 Writes SHALL reach the register file in strict program order (queue order), preserving WAW ordering to the same rd.
REQ-024 Simultaneous enqueue and dequeue in one cycle SHALL be supported; occupancy += accepted - dequeued (range 0..DEPTH, never overflows given REQ-019).
REQ-025 Pointers SHALL wrap modulo DEPTH; full = occupancy==DEPTH, empty = occupancy==0.
REQ-026 When empty, rf_we SHALL be 0 next cycle; rf_waddr/rf_wdata hold last values (don't-care when rf_we=0).
REQ-027 rd=0 SHALL be written like any other register (no hardwired zero).

Reset
REQ-028 On rst=1 at a rising edge: occupancy=0, pointers=0, rf_we=0, rf_waddr=0, rf_wdata=0, in_ready=1 next cycle.
REQ-029 rst SHALL dominate same-cycle requests; queued entries are discarded without writing; reset mid-drain aborts remaining writes.

Structure
REQ-030 Shared package wb_pkg SHALL hold DW, AW defaults and the queue entry type {rd[AW], data[DW]}.
REQ-031 Queue SHALL be a sub-module wb_fifo (2-write/1-read circular buffer, DEPTH entries); wb_arbiter holds lane muxing, ready logic and output registers.

Verification
REQ-032 Single ALU: l0_iswb=1, isld=0, rd=1, aluresult=ABCD at T -> rf_we=1, waddr=1, wdata=ABCD at T+1, then rf_we=0.
REQ-033 Dual: l0 rd=2 ld 1234 (isld=1), l1 rd=3 alu 5678 same cycle -> writes (2,1234) at T+1, (3,5678) at T+2.
REQ-034 WAW: l0 rd=4 data 1111, l1 rd=4 data 2222 -> writes in order 1111 then 2222; final reg4=2222.
REQ-035 Backpressure: dual requests 3 consecutive cycles -> in_ready drops when occupancy>2, no entry lost or duplicated, all 6 writes in order, occupancy returns to 0.
REQ-036 No-writeback: iswb=0 both lanes with aluresult=FEDC -> rf_we stays 0, occupancy 0.
REQ-037 Reset mid-drain: fill 4 entries, assert rst one cycle -> rf_we=0 next cycle, occupancy=0, no further writes of discarded entries.
